multiplicador_param: RTL
========================

Name: multiplicador_param

Overview:
- Parametrised sequential shift-add multiplier; next generation of the 16x16 multiplicador in MIPS_CPU/Multiplicador.
- Adds an operand-width parameter, a per-operation signed/unsigned mode, busy/done handshake and synchronous reset.
- Sits beside the ALU and serves MULT/MULTU. The 2*LARGURA-bit produto feeds the HI/LO registers.

Parameters:
LARGURA, 16, operand width in bits; legal values >= 2; produto is 2*LARGURA bits.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in state IDLE
sinal  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with start
multiplicando  input  LARGURA  operand A; sampled with start
multiplicador  input  LARGURA  operand B; sampled with start
produto  output  2*LARGURA  result register; held until the next completion
ocupado  output  1  high while an operation is in progress
pronto  output  1  one-cycle pulse: produto has just been updated

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, produto=0, ocupado=0, pronto=0, all internal registers 0. Takes priority over everything, including mid-operation; the aborted result is never written.
- Internal registers:
  - acc: 2*LARGURA bits.
  - mcand: 2*LARGURA bits, left-shifting.
  - mplier: LARGURA bits, right-shifting.
  - cnt: ceil(log2(LARGURA)) bits.
  - neg: 1 bit.
- IDLE, with start=1 at edge E0:
  - mcand <= |multiplicando| (zero-extended); mplier <= |multiplicador|.
  - |x| is the magnitude when sinal=1 and x is negative, otherwise x unchanged. The magnitude of -2^(LARGURA-1) is 2^(LARGURA-1) as unsigned; no overflow.
  - neg <= sinal & (msb A xor msb B).
  - acc <= 0, cnt <= 0, ocupado <= 1, go to CALC.
- IDLE, with start=0: hold all registers; pronto <= 0.
- CALC, each edge:
  - If mplier[0], acc <= acc + mcand (modulo 2^(2*LARGURA)).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - When cnt==LARGURA-1 (last iteration), go to AJUSTE.
- AJUSTE, one edge:
  - produto <= neg ? -acc : acc (2*LARGURA-bit two's complement).
  - pronto <= 1, ocupado <= 0, go to IDLE.
- Latency: start sampled at E0 gives pronto=1 and a valid produto in the cycle after edge E0+LARGURA+1, i.e. 17 cycles for LARGURA=16.
- ocupado is high after edges E0 .. E0+LARGURA.
- pronto is cleared at the next edge.
- start while ocupado=1 is ignored, and the operands are not resampled.
- start in the cycle pronto=1 (state IDLE) is accepted: a new operation begins and pronto drops.
- Operand changes after E0 have no effect on the running operation.
- produto never changes except in AJUSTE or on reset.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- When defined, CALC also exits to AJUSTE when (mplier>>1)==0 at the current edge, i.e. no set bits remain.
- CALC then lasts max(1, msb_index(|multiplicador|)+1) cycles; |multiplicador|=0 gives 1 CALC cycle.
- Result values are identical in either build.
- When undefined, CALC always lasts exactly LARGURA cycles.

Test Plan:
- LARGURA=16, sinal=0, start pulse with A=2, B=3 -> produto=6, pronto one cycle after edge E0+17, ocupado high for 17 cycles; with MULT_EARLY_TERM_EN, pronto after edge E0+3.
- sinal=0, A=65535, B=65535 -> produto=0xFFFE0001; the same operands with sinal=1 (-1*-1) -> produto=0x00000001.
- sinal=1, A=0xFFFE (-2), B=3 -> 0xFFFFFFFA; A=0x8000, B=0x8000 -> 0x40000000; A=0x8000, B=1 -> 0xFFFF8000.
- A=0 and B=0 in both modes -> produto=0; with MULT_EARLY_TERM_EN and B=0, pronto after edge E0+2.
- Start A=2, B=3; pulse start with A=5, B=5 at E0+4 -> the second start is ignored, result 6. Start A=5, B=5 in the pronto cycle -> accepted, result 25 after 17 more cycles.
- Start A=7, B=9, assert rst at E0+5 for one cycle -> produto=0, ocupado=0, pronto never pulses. A following start A=7, B=9 -> 63.

Source files
------------

// File: rtl/multiplicador_param_if.sv
// Operand/result bundle between a MULT/MULTU requester and the shift-add multiplier.
interface multiplicador_param_if #(parameter int LARGURA = 16);
  logic                   start;
  logic                   sinal;
  logic [LARGURA-1:0]     multiplicando;
  logic [LARGURA-1:0]     multiplicador;
  logic [2*LARGURA-1:0]   produto;
  logic                   ocupado;
  logic                   pronto;

  modport master (output start, sinal, multiplicando, multiplicador,
                  input  produto, ocupado, pronto);
  modport slave  (input  start, sinal, multiplicando, multiplicador,
                  output produto, ocupado, pronto);
endinterface

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier (signed/unsigned), LARGURA-bit operands, 2*LARGURA-bit result.
// Optional MULT_EARLY_TERM_EN: leave CALC as soon as no multiplier bits remain.
module multiplicador_param #(
  parameter int LARGURA = 16
) (
  input logic                  clk,
  input logic                  rst,
  multiplicador_param_if.slave bus
);
  localparam int W2 = 2 * LARGURA;
  localparam int CW = $clog2(LARGURA);

  typedef enum logic [1:0] {IDLE, CALC, AJUSTE} state_t;

  state_t             state, state_nx;
  logic [W2-1:0]      acc, mcand, prod_q;
  logic [LARGURA-1:0] mplier, mag_a, mag_b;
  logic [CW-1:0]      cnt;
  logic               neg, ocupado_q, pronto_q, last;

  // Work on magnitudes; the sign is reapplied once in AJUSTE.
  // -2^(LARGURA-1) maps onto itself, which is its correct unsigned magnitude.
  assign mag_a = (bus.sinal && bus.multiplicando[LARGURA-1]) ? -bus.multiplicando : bus.multiplicando;
  assign mag_b = (bus.sinal && bus.multiplicador[LARGURA-1]) ? -bus.multiplicador : bus.multiplicador;

`ifdef MULT_EARLY_TERM_EN
  assign last = (cnt == CW'(LARGURA - 1)) || ((mplier >> 1) == '0);
`else
  assign last = (cnt == CW'(LARGURA - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (last)      state_nx = AJUSTE;
      AJUSTE:                 state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      prod_q    <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand     <= {{LARGURA{1'b0}}, mag_a};
            mplier    <= mag_b;
            neg       <= bus.sinal & (bus.multiplicando[LARGURA-1] ^ bus.multiplicador[LARGURA-1]);
            acc       <= '0;
            cnt       <= '0;
            ocupado_q <= 1'b1;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        AJUSTE: begin
          prod_q    <= neg ? -acc : acc;
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.produto = prod_q;
  assign bus.ocupado = ocupado_q;
  assign bus.pronto  = pronto_q;
endmodule
